// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and data-phase state type for the SRAM slave.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase state: what the slave is doing on the cycle after an address phase
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } dphase_e;

  // Little-endian byte-lane enables for a legal, aligned transfer
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << lsb;
      HSIZE_HALF: lanes = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised memory: byte-enabled synchronous write, asynchronous read.
module ahb_sram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Write only the enabled byte lanes; other lanes keep their contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of an on-chip SRAM with optional wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
//
// Handshake: an address phase is taken only on a rising edge where hsel, hready
// and htrans[1] are all high; the data phase it starts ends on the first edge
// where hreadyout (and so hready) is high. Nothing is sampled while hready is low.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [31:0]           hwdata,
  output logic [31:0]           hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

  dphase_e          state;
  dphase_e          state_next;
  logic [3:0]       wait_cnt;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic             accept;
  logic             illegal;
  logic [3:0]       mem_we;
  logic [31:0]      mem_rdata;
  logic             unused_ok;

  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

  assign accept  = hsel && hready && htrans[1];
  assign illegal = ({1'b0, haddr} >= ADDR_LIMIT)
                || (hsize > HSIZE_WORD)
                || ((hsize == HSIZE_HALF) && haddr[0])
                || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

  // State register, captured address-phase fields and wait-state counter
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= haddr[IDX_W+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
      if ((state_next == ST_WAIT) && (state != ST_WAIT)) begin
        wait_cnt <= 4'(WAIT_STATES - 1);
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Next data-phase state: a finished phase may hand over to a new one on the same edge
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: if (wait_cnt == 4'd0) state_next = ST_OKAY;
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        if (hready) begin
          if (!accept)               state_next = ST_IDLE;
          else if (illegal)          state_next = ST_ERR1;
          else if (WAIT_STATES > 0)  state_next = ST_WAIT;
          else                       state_next = ST_OKAY;
        end
      end
    endcase
  end

  // Bus outputs and memory write strobes decoded from the data-phase state
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = 32'd0;
    mem_we    = 4'b0000;
    case (state)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (!write_q) hrdata = mem_rdata;
      end
      ST_OKAY: begin
        if (!write_q) hrdata = mem_rdata;
        else if (hready) mem_we = byte_lanes(size_q, addr_q[1:0]);
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  ahb_sram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (hclk),
    .we    (mem_we),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: one zero-wait and one two-wait-state slave share the bus
// signals; use_ws selects which one is addressed and drives hready.
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        use_ws = 1'b0;
  logic        hsel0, hsel2, hready;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = 2'd0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2, hresp0, hresp2;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  assign hsel0  = !use_ws;
  assign hsel2  = use_ws;
  assign hready = use_ws ? hreadyout2 : hreadyout0;

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hprot(4'b0011), .htrans(htrans), .hmastlock(1'b0),
    .hready(hready), .hwdata(hwdata), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hprot(4'b0011), .htrans(htrans), .hmastlock(1'b0),
    .hready(hready), .hwdata(hwdata), .hrdata(hrdata2), .hreadyout(hreadyout2), .hresp(hresp2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [1:0] tr);
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    htrans = tr;
  endtask

  task automatic idle_addr();
    htrans = T_IDLE;
    hwrite = 1'b0;
  endtask

  // Single word write followed by an idle cycle
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    drive_addr(1'b1, a, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = d;
    step();
  endtask

  // Single zero-wait word read checked on the data phase
  task automatic read_check0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_addr(1'b0, a, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'd0;
    check(tag, hrdata0, exp);
    step();
  endtask

  initial begin
    // Reset: outputs idle during and after reset
    #1 hresetn = 1'b0;
    #2;
    check("rst_hreadyout", {31'd0, hreadyout0}, 32'd1);
    check("rst_hresp", {31'd0, hresp0}, 32'd0);
    check("rst_hrdata", hrdata0, 32'd0);
    step();
    hresetn = 1'b1;
    check("post_rst_hreadyout", {31'd0, hreadyout0}, 32'd1);
    check("post_rst_hrdata", hrdata0, 32'd0);

    // Word write then pipelined read of the same address
    drive_addr(1'b1, 32'h10, SZ_W, T_NONSEQ);
    step();
    hwdata = 32'hDEAD_BEEF;
    drive_addr(1'b0, 32'h10, SZ_W, T_NONSEQ);
    check("wr_phase_ready", {31'd0, hreadyout0}, 32'd1);
    check("wr_phase_hrdata", hrdata0, 32'd0);
    step();
    idle_addr();
    check("word_rd", hrdata0, 32'hDEAD_BEEF);
    check("word_rd_ready", {31'd0, hreadyout0}, 32'd1);
    check("word_rd_resp", {31'd0, hresp0}, 32'd0);
    step();

    // Byte and halfword lane merging
    drive_addr(1'b1, 32'h20, SZ_W, T_NONSEQ);
    step();
    hwdata = 32'h0000_0000;
    drive_addr(1'b1, 32'h21, SZ_B, T_NONSEQ);
    step();
    hwdata = 32'h0000_AA00;
    drive_addr(1'b1, 32'h22, SZ_H, T_NONSEQ);
    step();
    hwdata = 32'h1234_0000;
    drive_addr(1'b0, 32'h20, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'd0;
    check("byte_half_merge", hrdata0, 32'h1234_AA00);
    step();

    // INCR4 writes followed at once by an INCR4 read
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_addr(1'b1, 32'h40 + 32'(4 * i), SZ_W, (i == 0) ? T_NONSEQ : T_SEQ);
      else       drive_addr(1'b0, 32'h40, SZ_W, T_NONSEQ);
      if (i > 0) hwdata = 32'(i);
      step();
    end
    hwdata = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) drive_addr(1'b0, 32'h44 + 32'(4 * j), SZ_W, T_SEQ);
      else       idle_addr();
      check($sformatf("incr4_rd%0d", j), hrdata0, 32'(j + 1));
      check($sformatf("incr4_ready%0d", j), {31'd0, hreadyout0}, 32'd1);
      step();
    end

    // Read immediately after a write to the same address
    drive_addr(1'b1, 32'h40, SZ_W, T_NONSEQ);
    step();
    hwdata = 32'h0000_0055;
    drive_addr(1'b0, 32'h40, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'd0;
    check("raw_same_addr", hrdata0, 32'h0000_0055);
    step();

    // Misaligned word write: two-cycle ERROR, memory untouched
    write_word(32'h0, 32'h0BAD_F00D);
    drive_addr(1'b1, 32'h2, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'hFFFF_FFFF;
    check("mis_err1_ready", {31'd0, hreadyout0}, 32'd0);
    check("mis_err1_resp", {31'd0, hresp0}, 32'd1);
    step();
    check("mis_err2_ready", {31'd0, hreadyout0}, 32'd1);
    check("mis_err2_resp", {31'd0, hresp0}, 32'd1);
    step();
    read_check0("mis_mem_kept", 32'h0, 32'h0BAD_F00D);

    // Out-of-range read: two-cycle ERROR with zero read data
    drive_addr(1'b0, 32'd1024, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    check("oor_err1_ready", {31'd0, hreadyout0}, 32'd0);
    check("oor_err1_resp", {31'd0, hresp0}, 32'd1);
    check("oor_err1_hrdata", hrdata0, 32'd0);
    step();
    check("oor_err2_ready", {31'd0, hreadyout0}, 32'd1);
    check("oor_err2_resp", {31'd0, hresp0}, 32'd1);
    step();

    // Oversized transfer is also an error
    drive_addr(1'b0, 32'h10, 3'd3, T_NONSEQ);
    step();
    idle_addr();
    check("size3_err1_resp", {31'd0, hresp0}, 32'd1);
    step();
    check("size3_err2_ready", {31'd0, hreadyout0}, 32'd1);
    step();
    read_check0("after_err_word10", 32'h10, 32'hDEAD_BEEF);

    // Two wait states: write then read of 0x10
    use_ws = 1'b1;
    drive_addr(1'b1, 32'h10, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'hCAFE_F00D;
    check("ws_wr_wait1", {31'd0, hreadyout2}, 32'd0);
    step();
    check("ws_wr_wait2", {31'd0, hreadyout2}, 32'd0);
    step();
    check("ws_wr_done", {31'd0, hreadyout2}, 32'd1);
    step();
    hwdata = 32'd0;
    drive_addr(1'b0, 32'h10, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    check("ws_rd_wait1", {31'd0, hreadyout2}, 32'd0);
    step();
    check("ws_rd_wait2", {31'd0, hreadyout2}, 32'd0);
    step();
    check("ws_rd_ready", {31'd0, hreadyout2}, 32'd1);
    check("ws_rd_data", hrdata2, 32'hCAFE_F00D);
    check("ws_rd_resp", {31'd0, hresp2}, 32'd0);
    step();

    // Reset during the wait cycles of a write aborts it
    drive_addr(1'b1, 32'h10, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    hwdata = 32'h1111_1111;
    step();
    hresetn = 1'b0;
    #1;
    check("ws_rst_ready", {31'd0, hreadyout2}, 32'd1);
    check("ws_rst_hrdata", hrdata2, 32'd0);
    step();
    hresetn = 1'b1;
    hwdata = 32'd0;
    drive_addr(1'b0, 32'h10, SZ_W, T_NONSEQ);
    step();
    idle_addr();
    step();
    step();
    check("ws_rst_ready_end", {31'd0, hreadyout2}, 32'd1);
    check("ws_rst_mem_kept", hrdata2, 32'hCAFE_F00D);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite (AMBA 3) slave wrapping a word-organised on-chip memory. Sits on the AHB-Lite bus behind the decoder.
- Accepts single and burst transfers of byte, halfword and word size.
- Returns OKAY with a configurable number of wait states.
- Returns a two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 256, number of 32-bit words; the legal byte range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted at the start of every OKAY data phase (0..15).

Ports:
- hclk  in  1  bus clock; all sequential logic on the rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  ADDR_WIDTH  byte address.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  transfer size: 0=byte, 1=halfword, 2=word.
- hburst  in  3  burst type; accepted, no effect on behaviour.
- hprot  in  4  protection; ignored.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hmastlock  in  1  ignored.
- hready  in  1  bus-level ready, i.e. the end of the previous data phase.
- hwdata  in  32  write data, valid in the data phase.
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (hresetn low, asynchronous):
  - hreadyout=1, hresp=0, hrdata=0.
  - Pending data phase cancelled; wait counter cleared.
  - Memory contents are not cleared.
- Address phase is accepted on a rising edge when hsel=1, hready=1 and htrans[1]=1.
  - At that edge, register haddr, hwrite and hsize, plus a valid flag.
  - IDLE, BUSY or hsel=0 with hready=1 clears the valid flag. The next cycle is an OKAY zero-wait phase with no memory access.
- Illegal access is any of:
  - haddr >= MEM_DEPTH*4;
  - hsize > 2;
  - misalignment: halfword with haddr[0]=1, or word with haddr[1:0]!=0.
- Error response (no memory access):
  - Cycle 1: hreadyout=0, hresp=1.
  - Cycle 2: hreadyout=1, hresp=1.
- OKAY data phase:
  - hreadyout=0 for WAIT_STATES cycles, then hreadyout=1, hresp=0.
- Writes:
  - Memory is updated at the rising edge that ends the write data phase (hreadyout=1), using hwdata at that edge.
  - Byte lanes are little-endian. Byte: lane haddr[1:0]. Halfword: lanes {haddr[1],0} and {haddr[1],1}. Word: all four lanes. Unselected lanes are preserved.
- Reads:
  - hrdata = mem[addr_q[..:2]], the full word, driven combinationally from the registered address throughout the read data phase.
  - hrdata=0 during write, idle and error phases.
  - A read immediately following a write to the same address returns the new data; no extra stall.
- Pipelining: a new address phase may be accepted on the same edge that completes the current data phase (hready=1). Back-to-back NONSEQ/SEQ transfers run at full rate when WAIT_STATES=0.
- hready low while selected: the address phase is not sampled and the registered state holds.
- Reset asserted mid-transfer aborts the transfer. A write not yet completed leaves memory unmodified.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS codes, HSIZE codes, HRESP OKAY/ERROR;
  - enum of data-phase states IDLE, WAIT, OKAY, ERR1, ERR2.
- Sub-module ahb_sram_array: MEM_DEPTH x 32 memory with 4-bit byte write-enable, synchronous write and asynchronous read.

Test Plan:
- Reset: hresetn low for 1 cycle then high -> hreadyout=1, hresp=0, hrdata=0 during and after reset.
- Word write/read: NONSEQ write 0x0000_0010 data 0xDEAD_BEEF, then NONSEQ read 0x10 -> hrdata=0xDEADBEEF, hresp=0, zero wait states.
- Byte and halfword writes:
  - Pre-load word 0x20 = 0x0000_0000.
  - Byte write 0xAA to 0x21.
  - Halfword write 0x1234 to 0x22.
  - Read 0x20 -> 0x1234_AA00.
- Back-to-back INCR4:
  - Word writes to 0x40..0x4C with data 1,2,3,4.
  - Then INCR4 read of the same addresses -> 1,2,3,4 on consecutive cycles.
  - Read of 0x40 directly after the last write returns the new data.
- Errors, each giving a 2-cycle ERROR (hreadyout 0 then 1, hresp=1) and leaving memory unchanged:
  - word write to 0x0000_0002 (misaligned);
  - read of address MEM_DEPTH*4 (out of range).
- WAIT_STATES=2: a read of 0x10 holds hreadyout low 2 cycles, then returns data with hreadyout=1. Asserting reset during the wait cycles of a write leaves the target word unchanged.
